// File: rtl/xgmii_pkg.sv
`default_nettype none
// xgmii_pkg: shared XGMII word type, control codes, Ethernet constants and CRC-32 byte step.
// Revision: 1.0
package xgmii_pkg;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } xgmii_t;

  localparam logic [7:0]  XGMII_START     = 8'hFB;
  localparam logic [7:0]  XGMII_TERM      = 8'hFD;
  localparam logic [7:0]  XGMII_IDLE      = 8'h07;
  localparam logic [7:0]  XGMII_ERROR     = 8'hFE;
  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

  localparam xgmii_t XGMII_IDLE_WORD = '{data: {8{XGMII_IDLE}}, ctrl: 8'hFF};

  // One byte of reflected CRC-32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d64_var.sv
`default_nettype none
// crc32_d64_var: combinational CRC-32 over the lowest nbytes (0..8) of a 64-bit word, lane 0 first.
// Revision: 1.0
module crc32_d64_var
  import xgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [3:0]  nbytes,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nbytes)) begin
        crc_out = crc32_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xgmii_rx_fcs_check.sv
`default_nettype none
// xgmii_rx_fcs_check: 2-cycle pass-through XGMII RX monitor checking Ethernet FCS per frame.
// Revision: 1.0
module xgmii_rx_fcs_check
  import xgmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  xgmii_t           xgmii_rxi,
  output xgmii_t           xgmii_rxo,
  output logic             stat_valid,
  output logic             stat_fcs_ok,
  output logic             stat_err,
  output logic             stat_runt,
  output logic [LEN_W-1:0] stat_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_DATA    = 1'b1;
  localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);

  xgmii_t           rx_q;
  logic [0:0]       state;
  logic [31:0]      crc;
  logic [LEN_W-1:0] len;
  logic             err;

  logic             is_start;
  logic             term_found;
  logic [3:0]       term_lane;
  logic             ctrl_bad;
  logic [31:0]      crc_next;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] len_next;
  logic             err_next;
  logic             frame_ok;
  logic             runt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q      <= XGMII_IDLE_WORD;
      xgmii_rxo <= XGMII_IDLE_WORD;
    end else begin
      rx_q      <= xgmii_rxi;
      xgmii_rxo <= rx_q;
    end
  end

  // term_lane doubles as the byte count: 8 when no /T/ is present, so any ctrl lane below it is an error.
  always_comb begin
    is_start = (rx_q.ctrl == 8'h01) && (rx_q.data[7:0] == XGMII_START) &&
               (rx_q.data[63:56] == ETH_SFD);
    for (int i = 1; i < 7; i++) begin
      if (rx_q.data[8*i +: 8] != ETH_PREAMBLE) is_start = 1'b0;
    end
    term_found = 1'b0;
    term_lane  = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (rx_q.ctrl[i] && (rx_q.data[8*i +: 8] == XGMII_TERM)) begin
        term_found = 1'b1;
        term_lane  = 4'(i);
      end
    end
    ctrl_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) < term_lane) && rx_q.ctrl[i]) ctrl_bad = 1'b1;
    end
  end

  crc32_d64_var u_crc (
    .crc_in  (crc),
    .data    (rx_q.data),
    .nbytes  (term_lane),
    .crc_out (crc_next)
  );

  assign len_sum   = {1'b0, len} + (LEN_W+1)'(term_lane);
  assign len_next  = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
  assign err_next  = err | ctrl_bad;
  assign frame_ok  = (crc_next == ETH_CRC_RESIDUE) & ~err_next;
  assign runt_next = (len_next < MIN_LEN_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      crc         <= ETH_CRC_INIT;
      len         <= '0;
      err         <= 1'b0;
      stat_valid  <= 1'b0;
      stat_fcs_ok <= 1'b0;
      stat_err    <= 1'b0;
      stat_runt   <= 1'b0;
      stat_len    <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      stat_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (is_start) begin
          state <= S_DATA;
          crc   <= ETH_CRC_INIT;
          len   <= '0;
          err   <= 1'b0;
        end
      end else if (is_start) begin
        // Abort the frame in flight; the new frame starts on this same word.
        stat_valid  <= 1'b1;
        stat_fcs_ok <= 1'b0;
        stat_err    <= 1'b1;
        stat_runt   <= (len < MIN_LEN_V);
        stat_len    <= len;
        bad_cnt     <= bad_cnt + CNT_W'(1);
        crc         <= ETH_CRC_INIT;
        len         <= '0;
        err         <= 1'b0;
      end else if (term_found) begin
        stat_valid  <= 1'b1;
        stat_fcs_ok <= frame_ok;
        stat_err    <= err_next;
        stat_runt   <= runt_next;
        stat_len    <= len_next;
        if (frame_ok && !runt_next) good_cnt <= good_cnt + CNT_W'(1);
        else                        bad_cnt  <= bad_cnt + CNT_W'(1);
        state       <= S_IDLE;
      end else begin
        crc <= crc_next;
        len <= len_next;
        err <= err_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xgmii_rx_fcs_check.sv
`default_nettype none
// tb_xgmii_rx_fcs_check: table-driven, directed and randomized frames checked against a byte-level model.
// Revision: 1.0
module tb_xgmii_rx_fcs_check;
  import xgmii_pkg::*;

  localparam int MIN_LEN = 64;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  xgmii_t           xgmii_rxi;
  xgmii_t           xgmii_rxo;
  logic             stat_valid, stat_fcs_ok, stat_err, stat_runt;
  logic [LEN_W-1:0] stat_len;
  logic [CNT_W-1:0] good_cnt, bad_cnt;

  xgmii_rx_fcs_check #(.MIN_LEN(MIN_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .xgmii_rxi   (xgmii_rxi),
    .xgmii_rxo   (xgmii_rxo),
    .stat_valid  (stat_valid),
    .stat_fcs_ok (stat_fcs_ok),
    .stat_err    (stat_err),
    .stat_runt   (stat_runt),
    .stat_len    (stat_len),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    xgmii_t           w;
    logic             sv;
    logic             ok;
    logic             err;
    logic             runt;
    logic [LEN_W-1:0] len;
  } rec_t;
  typedef struct {
    int   len;
    int   flip;
    int   epos;
    logic ok;
    logic err;
    logic runt;
  } vec_t;

  rec_t             tx[$];
  rec_t             hist[$];
  int               n_chk  = 0;
  int               n_pass = 0;
  logic [CNT_W-1:0] exp_good = '0;
  logic [CNT_W-1:0] exp_bad  = '0;
  vec_t             vecs[11];

  function automatic xgmii_t idle_w();
    xgmii_t w;
    w.data = {8{XGMII_IDLE}};
    w.ctrl = 8'hFF;
    return w;
  endfunction

  function automatic xgmii_t start_w();
    xgmii_t w;
    w.data = {ETH_SFD, {6{ETH_PREAMBLE}}, XGMII_START};
    w.ctrl = 8'h01;
    return w;
  endfunction

  // Bit-serial CRC-32 over a byte list, no final inversion.
  function automatic logic [31:0] model_crc(input bq_t b);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[k][j];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    end
    return c;
  endfunction

  function automatic bq_t make_frame(input int len, input int flip);
    bq_t         b;
    logic [31:0] f;
    for (int i = 0; i < len - 4; i++) b.push_back(8'($urandom));
    f = ~model_crc(b);
    for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
    if (flip >= 0) b[len - 4 + flip / 8] = b[len - 4 + flip / 8] ^ 8'(1 << (flip % 8));
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input xgmii_t w, input logic sv, input logic ok, input logic err,
                      input logic runt, input logic [LEN_W-1:0] len);
    rec_t r;
    r.w = w; r.sv = sv; r.ok = ok; r.err = err; r.runt = runt; r.len = len;
    tx.push_back(r);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) push(idle_w(), 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Start word, packed data words, /T/ after the last byte; status expected on the /T/ word.
  task automatic queue_frame(input bq_t b, input int epos, input logic ok, input logic err,
                             input logic runt);
    xgmii_t           w;
    int               len;
    int               p;
    logic [LEN_W-1:0] slen;
    len  = b.size();
    slen = (len >= (1 << LEN_W)) ? {LEN_W{1'b1}} : LEN_W'(len);
    push(start_w(), 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k <= len / 8; k++) begin
      w.data = '0;
      w.ctrl = '0;
      for (int l = 0; l < 8; l++) begin
        p = 8 * k + l;
        if (p < len) begin
          w.data[8*l +: 8] = b[p];
          if (p == epos) begin
            w.ctrl[l]        = 1'b1;
            w.data[8*l +: 8] = XGMII_ERROR;
          end
        end else begin
          w.ctrl[l]        = 1'b1;
          w.data[8*l +: 8] = (p == len) ? XGMII_TERM : XGMII_IDLE;
        end
      end
      push(w, (k == len / 8), ok, err, runt, slen);
    end
  endtask

  task automatic model_frame(input int len, input int flip, input int epos);
    bq_t b;
    b = make_frame(len, flip);
    queue_frame(b, epos, (model_crc(b) == ETH_CRC_RESIDUE) && (epos < 0), (epos >= 0),
                (len < MIN_LEN));
  endtask

  task automatic check_out();
    rec_t e;
    e = hist.pop_front();
    chk("rxo_data", xgmii_rxo.data, e.w.data);
    chk("rxo_ctrl", 64'(xgmii_rxo.ctrl), 64'(e.w.ctrl));
    chk("stat_valid", 64'(stat_valid), 64'(e.sv));
    if (e.sv) begin
      if (e.ok && !e.err && !e.runt) exp_good++;
      else exp_bad++;
      chk("stat_fcs_ok", 64'(stat_fcs_ok), 64'(e.ok));
      chk("stat_err", 64'(stat_err), 64'(e.err));
      chk("stat_runt", 64'(stat_runt), 64'(e.runt));
      chk("stat_len", 64'(stat_len), 64'(e.len));
    end
    chk("good_cnt", 64'(good_cnt), 64'(exp_good));
    chk("bad_cnt", 64'(bad_cnt), 64'(exp_bad));
  endtask

  task automatic run_tx();
    while (tx.size() > 0) begin
      @(negedge clk);
      check_out();
      xgmii_rxi = tx[0].w;
      hist.push_back(tx.pop_front());
    end
  endtask

  task automatic do_reset();
    rec_t r;
    @(negedge clk);
    rst       = 1'b1;
    xgmii_rxi = idle_w();
    @(negedge clk);
    @(negedge clk);
    chk("rst_rxo_data", xgmii_rxo.data, {8{XGMII_IDLE}});
    chk("rst_rxo_ctrl", 64'(xgmii_rxo.ctrl), 64'hFF);
    chk("rst_stat_valid", 64'(stat_valid), 64'd0);
    chk("rst_stat_fields", 64'({stat_fcs_ok, stat_err, stat_runt}), 64'd0);
    chk("rst_stat_len", 64'(stat_len), 64'd0);
    chk("rst_good_cnt", 64'(good_cnt), 64'd0);
    chk("rst_bad_cnt", 64'(bad_cnt), 64'd0);
    rst = 1'b0;
    hist.delete();
    r.w = idle_w(); r.sv = 1'b0; r.ok = 1'b0; r.err = 1'b0; r.runt = 1'b0; r.len = '0;
    hist.push_back(r);
    hist.push_back(r);
    exp_good = '0;
    exp_bad  = '0;
  endtask

  initial begin
    int   idx;
    rec_t r;
    xgmii_t w;

    for (int i = 0; i < 8; i++) vecs[i] = '{64 + i, -1, -1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{64, 13, -1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{64, -1, 27, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{40, -1, -1, 1'b1, 1'b0, 1'b1};

    xgmii_rxi = idle_w();
    do_reset();

    foreach (vecs[i]) begin
      queue_frame(make_frame(vecs[i].len, vecs[i].flip), vecs[i].epos,
                  vecs[i].ok, vecs[i].err, vecs[i].runt);
      idles(2);
      run_tx();
    end

    // Start while in a frame: abort after 24 bytes, then the new frame must check good.
    push(start_w(), 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      w.data = {$urandom, $urandom};
      w.ctrl = '0;
      push(w, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    idx = tx.size();
    queue_frame(make_frame(64, -1), -1, 1'b1, 1'b0, 1'b0);
    r = tx[idx];
    r.sv = 1'b1; r.ok = 1'b0; r.err = 1'b1; r.runt = 1'b1; r.len = LEN_W'(24);
    tx[idx] = r;
    idles(2);
    run_tx();

    // Start word with a corrupted SFD is ignored, as is the rest of that burst.
    w = start_w();
    w.data[63:56] = 8'hD4;
    push(w, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      w.data = {$urandom, $urandom};
      w.ctrl = '0;
      push(w, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    w.data = {{7{XGMII_IDLE}}, XGMII_TERM};
    w.ctrl = 8'hFF;
    push(w, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idles(2);
    run_tx();

    // Reset in the middle of a frame.
    push(start_w(), 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      w.data = {$urandom, $urandom};
      w.ctrl = '0;
      push(w, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    run_tx();
    do_reset();

    for (int i = 0; i < 24; i++) begin
      int len, flip, epos;
      len  = int'($urandom_range(40, 160));
      flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
      epos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      model_frame(len, flip, epos);
      idles(int'($urandom_range(1, 3)));
      run_tx();
    end

    // Length beyond the counter range saturates.
    model_frame(65600, -1, -1);
    idles(3);
    run_tx();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
